// File: rtl/sid_bus_master.sv
// sid_bus_master: SID register bus initiator.
// Host register requests are queued in a small FIFO. The block generates phi2
// and launches one queued access per phi2 period. Each period is PHI2_HALF
// clocks with phi2 low, then PHI2_HALF clocks with phi2 high. Read data is
// captured from data_i at the end of the period and returned on a
// single-cycle rsp_valid strobe.
//
// Parameters:
//   PHI2_HALF  - clk cycles per phi2 half period (2..255)
//   FIFO_DEPTH - request FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, res                 - clock, asynchronous active-high reset
//   clr                      - start a register clear sequence
//                              (only with SID_BUS_MASTER_CLEAR_EN)
//   req_valid/req_ready      - request handshake
//   req_r_w_n/cs/addr/data   - request payload (1 = read)
//   rsp_valid/rsp_data       - read response strobe and data
//   bus_phi2/r_w_n/cs/addr/data - SID bus outputs, held for a whole period
//   data_i                   - read data from the SID register block
//   busy                     - FIFO non-empty or a non-idle access on the bus
//
// Optional feature macro: SID_BUS_MASTER_CLEAR_EN. When it is defined, the
// clr port and a sequencer are added. The sequencer writes 0x00 to
// registers 0x00..0x18 on both chips.
module sid_bus_master #(
    parameter int unsigned PHI2_HALF  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       res,
`ifdef SID_BUS_MASTER_CLEAR_EN
    input  logic       clr,
`endif
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_r_w_n,
    input  logic [1:0] req_cs,
    input  logic [4:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       bus_phi2,
    output logic       bus_r_w_n,
    output logic [1:0] bus_cs,
    output logic [4:0] bus_addr,
    output logic [7:0] bus_data,
    input  logic [7:0] data_i,
    output logic       busy
);

    localparam int unsigned PW   = 8;
    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned PTRW = AW + 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(PHI2_HALF - 1);

    // One bus access: direction, chip selects, register address, write data
    typedef struct packed {
        logic       r_w_n;
        logic [1:0] cs;
        logic [4:0] addr;
        logic [7:0] data;
    } sid_req_t;

    localparam sid_req_t BUS_RESET = '{r_w_n: 1'b1, cs: 2'b00, addr: 5'd0, data: 8'd0};

    // State registers and their next-state values
    logic [PW-1:0]   phase_q, phase_d;
    logic            phi2_q, phi2_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    sid_req_t        bus_q, bus_d;
    logic            active_q, active_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;

    sid_req_t        fifo_q [FIFO_DEPTH];

    logic            boundary_c;
    logic            empty_c;
    logic            full_d_c;
    logic            push_c;
    logic            pop_c;
    sid_req_t        req_c;

    // Clear sequencer hooks. In the default build they are tied off.
    logic            clear_launch_c;
    logic            clr_act_d;
    logic [4:0]      clr_addr_c;

    // Period boundary: the edge on which phi2 falls
    assign boundary_c = phi2_q && (phase_q == PHASE_LAST);
    assign empty_c    = (wr_ptr_q == rd_ptr_q);
    assign push_c     = req_valid && ready_q;
    assign pop_c      = boundary_c && !empty_c && !clear_launch_c;
    assign req_c      = '{r_w_n: req_r_w_n, cs: req_cs, addr: req_addr, data: req_data};

`ifdef SID_BUS_MASTER_CLEAR_EN
    localparam logic [4:0] CLR_WRITES = 5'd25;

    logic            clr_act_q;
    logic [4:0]      clr_cnt_q, clr_cnt_d;

    // Clear sequencer: accepted only when idle. It counts launched writes,
    // then waits for the boundary that ends the last write.
    always_comb begin
        clr_act_d      = clr_act_q;
        clr_cnt_d      = clr_cnt_q;
        clear_launch_c = 1'b0;
        if (clr_act_q) begin
            if (boundary_c) begin
                if (clr_cnt_q == CLR_WRITES) begin
                    clr_act_d = 1'b0;
                end else begin
                    clear_launch_c = 1'b1;
                    clr_cnt_d      = clr_cnt_q + 5'd1;
                end
            end
        end else if (clr && !busy_q) begin
            clr_act_d = 1'b1;
            clr_cnt_d = 5'd0;
        end
    end

    assign clr_addr_c = clr_cnt_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            clr_act_q <= 1'b0;
            clr_cnt_q <= 5'd0;
        end else begin
            clr_act_q <= clr_act_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end
`else
    assign clear_launch_c = 1'b0;
    assign clr_act_d      = 1'b0;
    assign clr_addr_c     = 5'd0;
`endif

    // Next-state logic: phase generator, FIFO pointers, capture/launch at boundary
    always_comb begin
        phase_d     = phase_q + PW'(1);
        phi2_d      = phi2_q;
        wr_ptr_d    = wr_ptr_q + PTRW'(push_c);
        rd_ptr_d    = rd_ptr_q + PTRW'(pop_c);
        bus_d       = bus_q;
        active_d    = active_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        if (phase_q == PHASE_LAST) begin
            phase_d = '0;
            phi2_d  = !phi2_q;
        end

        if (boundary_c) begin
            // The access that ends now returns its read data
            if (bus_q.r_w_n && (bus_q.cs != 2'b00)) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = data_i;
            end
            if (clear_launch_c) begin
                bus_d    = '{r_w_n: 1'b0, cs: 2'b11, addr: clr_addr_c, data: 8'd0};
                active_d = 1'b1;
            end else if (pop_c) begin
                bus_d    = fifo_q[rd_ptr_q[AW-1:0]];
                active_d = 1'b1;
            end else begin
                // Idle period: deselect and leave addr/data as they were
                bus_d.r_w_n = 1'b1;
                bus_d.cs    = 2'b00;
                active_d    = 1'b0;
            end
        end

        full_d_c = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        ready_d  = !full_d_c && !clr_act_d;
        busy_d   = (wr_ptr_d != rd_ptr_d) || active_d || clr_act_d;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            phase_q     <= '0;
            phi2_q      <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            bus_q       <= BUS_RESET;
            active_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            phi2_q      <= phi2_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            bus_q       <= bus_d;
            active_q    <= active_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    // FIFO storage. It needs no reset because the pointers qualify every entry.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q[AW-1:0]] <= req_c;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign bus_phi2  = phi2_q;
    assign bus_r_w_n = bus_q.r_w_n;
    assign bus_cs    = bus_q.cs;
    assign bus_addr  = bus_q.addr;
    assign bus_data  = bus_q.data;
    assign busy      = busy_q;

endmodule
